// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//   Owns the single write port of the register file. The write port is shared by
//   the in-order writeback stage (WB) and a long-latency unit (LU, mul/div). WB has
//   fixed priority. A per-register pending scoreboard tracks outstanding LU
//   destinations and stalls decode on RAW/WAW hazards against them. A starvation
//   guard forces a decode stall so that WB drains and the LU result gets a turn.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   issue_valid/long/rd         decode-stage issue request and its destination
//   dec_rs, dec_rt              decode-stage source registers
//   stall_o                     hold decode this cycle (combinational)
//   wb_valid/rd/data            writeback result, cannot be back-pressured
//   lu_valid/rd/data, lu_ready  LU result handshake (lu_ready combinational)
//   rf_we/waddr/wdata           registered register-file write port
//   pending_o                   scoreboard, one bit per register
module regfile_write_scheduler #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic                 issue_long,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic [ADDR_W-1:0]    dec_rs,
  input  logic [ADDR_W-1:0]    dec_rt,
  output logic                 stall_o,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_rd,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 lu_valid,
  input  logic [ADDR_W-1:0]    lu_rd,
  input  logic [DATA_W-1:0]    lu_data,
  output logic                 lu_ready,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pending_o
);

  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic lu_acc;
  logic issue_acc;
  logic hazard;

  // Handshake and hazard detection
  always_comb begin
    lu_ready  = !reset && !wb_valid;
    lu_acc    = lu_valid && lu_ready;
    // Hazards look only at registered pending bits, so an LU accept in this
    // cycle releases the stall one cycle later, together with the rf write.
    hazard    = ((dec_rs != '0) && pending_q[dec_rs]) ||
                ((dec_rt != '0) && pending_q[dec_rt]) ||
                (issue_long && (issue_rd != '0) && pending_q[issue_rd]) ||
                (state_q == ST_DRAIN);
    stall_o   = !reset && issue_valid && hazard;
    issue_acc = issue_valid && !stall_o;
  end

  // Scoreboard: clear applied before set so a same-cycle set wins
  always_comb begin
    pending_d = pending_q;
    if (lu_acc && (lu_rd != '0)) begin
      pending_d[lu_rd] = 1'b0;
    end
    if (issue_acc && issue_long && (issue_rd != '0)) begin
      pending_d[issue_rd] = 1'b1;
    end
  end

  // Write-port arbitration; register 0 is never written
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_valid) begin
      if (wb_rd != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = wb_rd;
        rf_wdata_d = wb_data;
      end
    end else if (lu_valid) begin
      if (lu_rd != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = lu_rd;
        rf_wdata_d = lu_data;
      end
    end
  end

  // Starvation guard
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (lu_valid && wb_valid) begin
          cnt_d   = CNT_ONE;
          state_d = (CNT_ONE == CNT_LIMIT) ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT, ST_DRAIN: begin
        // Accept, or lu_valid dropped (protocol error): back to IDLE either way.
        if (!lu_valid || lu_acc) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q != CNT_LIMIT) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (cnt_d == CNT_LIMIT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd, dec_rs, dec_rt;
  logic        stall_o;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .stall_o(stall_o),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending_o(pending_o)
  );

  typedef struct {
    logic        iv, il;
    logic [4:0]  ird, rs, rt;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        stall, lrdy, we;
    logic [4:0]  wa;
    logic [31:0] wdat;
    logic [31:0] pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic il, logic [4:0] ird, logic [4:0] rs, logic [4:0] rt,
                              logic wv, logic [4:0] wrd, logic [31:0] wd,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic stall, logic lrdy, logic we, logic [4:0] wa,
                              logic [31:0] wdat, logic [31:0] pend);
    vec_t v;
    v.iv = iv; v.il = il; v.ird = ird; v.rs = rs; v.rt = rt;
    v.wv = wv; v.wrd = wrd; v.wd = wd;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.stall = stall; v.lrdy = lrdy; v.we = we; v.wa = wa; v.wdat = wdat; v.pend = pend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    issue_valid = 0; issue_long = 0; issue_rd = 0; dec_rs = 0; dec_rt = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  // Inputs are driven just after a posedge; combinational outputs are checked
  // mid-cycle, registered outputs 1 time unit after the next posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    #12;
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_waddr", 64'(rf_waddr), 64'd0);
    chk("reset_wdata", 64'(rf_wdata), 64'd0);
    chk("reset_pending", 64'(pending_o), 64'd0);
    chk("reset_lu_ready", 64'(lu_ready), 64'd0);
    issue_valid = 1; lu_valid = 1;
    #1;
    chk("reset_stall", 64'(stall_o), 64'd0);
    chk("reset_lu_ready_lv", 64'(lu_ready), 64'd0);
    clr();
    @(posedge clk); #1;
    reset = 1'b0;

    //        iv il ird rs rt  wv wrd wd       lv lrd ld       stall lrdy we wa wdat     pend
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,        0,0,0,          0,1,0,0,0,        32'h0));
    vecs.push_back(mk(1,0,6,1,2, 1,3,32'h33,   0,0,0,          0,0,1,3,32'h33,   32'h0));
    vecs.push_back(mk(1,1,5,0,0, 0,0,0,        0,0,0,          0,1,0,0,0,        32'h20));
    vecs.push_back(mk(1,0,6,5,0, 0,0,0,        0,0,0,          1,1,0,0,0,        32'h20));
    vecs.push_back(mk(1,0,6,0,5, 0,0,0,        0,0,0,          1,1,0,0,0,        32'h20));
    vecs.push_back(mk(1,1,5,0,0, 0,0,0,        0,0,0,          1,1,0,0,0,        32'h20));
    vecs.push_back(mk(1,0,6,5,0, 0,0,0,        1,5,32'h55,     1,1,1,5,32'h55,   32'h0));
    vecs.push_back(mk(1,0,6,5,0, 0,0,0,        0,0,0,          0,1,0,0,0,        32'h0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,32'hA3,   1,4,32'hB4,     0,0,1,3,32'hA3,   32'h0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,        1,4,32'hB4,     0,1,1,4,32'hB4,   32'h0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,        1,0,32'h77,     0,1,0,0,0,        32'h0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,32'h99,   0,0,0,          0,0,0,0,0,        32'h0));
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,        0,0,0,          0,1,0,0,0,        32'h0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,        1,7,32'h70,     0,1,1,7,32'h70,   32'h0));
    vecs.push_back(mk(1,1,7,0,0, 0,0,0,        1,7,32'h71,     0,1,1,7,32'h71,   32'h80));
    vecs.push_back(mk(1,1,7,0,0, 0,0,0,        0,0,0,          1,1,0,0,0,        32'h80));
    vecs.push_back(mk(0,0,0,0,0, 1,2,32'h22,   1,7,32'h72,     0,0,1,2,32'h22,   32'h80));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,        1,7,32'h72,     0,1,1,7,32'h72,   32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      issue_valid = vecs[i].iv; issue_long = vecs[i].il; issue_rd = vecs[i].ird;
      dec_rs = vecs[i].rs; dec_rt = vecs[i].rt;
      wb_valid = vecs[i].wv; wb_rd = vecs[i].wrd; wb_data = vecs[i].wd;
      lu_valid = vecs[i].lv; lu_rd = vecs[i].lrd; lu_data = vecs[i].ld;
      #2;
      chk($sformatf("v%0d_stall", i), 64'(stall_o), 64'(vecs[i].stall));
      chk($sformatf("v%0d_lu_ready", i), 64'(lu_ready), 64'(vecs[i].lrdy));
      tick();
      chk($sformatf("v%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_waddr", i), 64'(rf_waddr), 64'(vecs[i].wa));
        chk($sformatf("v%0d_wdata", i), 64'(rf_wdata), 64'(vecs[i].wdat));
      end
      chk($sformatf("v%0d_pending", i), 64'(pending_o), 64'(vecs[i].pend));
    end
    clr();

    // Starvation: WB busy every cycle while LU waits; drain stall from cycle 8.
    for (int j = 0; j < 12; j++) begin
      issue_valid = 1; wb_valid = 1; wb_rd = 9; wb_data = 32'(j);
      lu_valid = 1; lu_rd = 10; lu_data = 32'hABCD;
      #2;
      chk($sformatf("starve%0d_stall", j), 64'(stall_o), (j >= 8) ? 64'd1 : 64'd0);
      chk($sformatf("starve%0d_lu_ready", j), 64'(lu_ready), 64'd0);
      tick();
      chk($sformatf("starve%0d_waddr", j), 64'(rf_waddr), 64'd9);
    end
    wb_valid = 0;
    #2;
    chk("bubble_stall", 64'(stall_o), 64'd1);
    chk("bubble_lu_ready", 64'(lu_ready), 64'd1);
    tick();
    chk("bubble_rf_we", 64'(rf_we), 64'd1);
    chk("bubble_waddr", 64'(rf_waddr), 64'd10);
    chk("bubble_wdata", 64'(rf_wdata), 64'hABCD);
    lu_valid = 0;
    #2;
    chk("after_drain_stall", 64'(stall_o), 64'd0);
    tick();

    // Reset while in DRAIN with a pending register outstanding.
    clr();
    issue_valid = 1; issue_long = 1; issue_rd = 12;
    tick();
    chk("pre_rst_pending", 64'(pending_o), 64'h1000);
    clr();
    for (int j = 0; j < 9; j++) begin
      wb_valid = 1; wb_rd = 1; wb_data = 32'h11;
      lu_valid = 1; lu_rd = 12; lu_data = 32'hC;
      tick();
    end
    issue_valid = 1;
    #2;
    chk("pre_rst_drain_stall", 64'(stall_o), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_lu_ready", 64'(lu_ready), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_pending", 64'(pending_o), 64'd0);
    clr();
    tick();
    reset = 1'b0;
    issue_valid = 1; dec_rs = 12;
    #2;
    chk("post_rst_stall", 64'(stall_o), 64'd0);
    tick();
    chk("post_rst_rf_we", 64'(rf_we), 64'd0);
    // One blocked cycle then a bubble must not trigger DRAIN (FSM left IDLE cleanly).
    clr();
    issue_valid = 1; wb_valid = 1; wb_rd = 2; lu_valid = 1; lu_rd = 3;
    tick();
    wb_valid = 0;
    #2;
    chk("post_rst_idle_stall", 64'(stall_o), 64'd0);
    tick();
    chk("post_rst_lu_write", 64'(rf_waddr), 64'd3);
    clr();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
